// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the iterative FPU significand divider.
// Holds the state encoding, flag/class bit positions and special-case flag logic.
package fpu_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    localparam int FLR_ZERO = 57;
    localparam int FLR_NAN  = 56;
    localparam int FLR_INF  = 55;
    localparam int FLR_INV  = 54;
    localparam int FLR_DBZ  = 53;

    localparam int CLS_ZERO = 3;
    localparam int CLS_INF  = 2;
    localparam int CLS_NAN  = 1;
    localparam int CLS_SNAN = 0;

    localparam logic [52:0] DEFAULT_QNAN = {1'b0, 1'b1, 51'b0};

    localparam int DB_ITERS = 56;
    localparam int SP_ITERS = 26;
    localparam int CNT_W    = 6;

    // First matching rule wins; a signalling NaN counts as a NaN operand.
    function automatic logic [57:0] special_flags(
        input logic [3:0]  ca,
        input logic [3:0]  cb,
        input logic [50:0] pa,
        input logic [50:0] pb
    );
        logic       a_nan;
        logic       b_nan;
        logic [57:0] f;
        a_nan = ca[CLS_NAN] | ca[CLS_SNAN];
        b_nan = cb[CLS_NAN] | cb[CLS_SNAN];
        f = '0;
        if (a_nan | b_nan) begin
            f[FLR_NAN] = 1'b1;
            f[FLR_INV] = ca[CLS_SNAN] | cb[CLS_SNAN];
            f[52:0]    = {2'b01, (a_nan ? pa : pb)};
        end else if ((ca[CLS_ZERO] & cb[CLS_ZERO]) | (ca[CLS_INF] & cb[CLS_INF])) begin
            f[FLR_NAN] = 1'b1;
            f[FLR_INV] = 1'b1;
            f[52:0]    = DEFAULT_QNAN;
        end else if (ca[CLS_INF]) begin
            f[FLR_INF] = 1'b1;
        end else if (cb[CLS_ZERO]) begin
            f[FLR_DBZ] = 1'b1;
            f[FLR_INF] = 1'b1;
        end else if (ca[CLS_ZERO] | cb[CLS_INF]) begin
            f[FLR_ZERO] = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/fdiv_iter_div_step.sv
// One combinational restoring-division iteration: compare, conditionally subtract, shift.
module div_step (
    input  logic [53:0] rem,
    input  logic [53:0] div,
    output logic        qbit,
    output logic [53:0] rem_next
);

    logic [53:0] diff;

    // The partial remainder stays below 2*div, so the left shift never drops a set bit.
    assign diff     = rem - div;
    assign qbit     = (rem >= div);
    assign rem_next = (qbit ? diff : rem) << 1;

endmodule

// File: rtl/fdiv_iter.sv
// Iterative restoring significand divider feeding the FPU rounder.
// One quotient bit per cycle in DIV; specials bypass straight to DONE.
module fdiv_iter
    import fpu_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        db_in,
    input  logic [1:0]  rm_in,
    input  logic        sa,
    input  logic        sb,
    input  logic [12:0] ea,
    input  logic [12:0] eb,
    input  logic [52:0] fa,
    input  logic [52:0] fb,
    input  logic [3:0]  cls_a,
    input  logic [3:0]  cls_b,
    input  logic [51:0] nan_a,
    input  logic [51:0] nan_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        s,
    output logic [12:0] er,
    output logic [56:0] fr,
    output logic [57:0] flr,
    output logic        db,
    output logic [1:0]  RM
);

    state_t           state;
    state_t           state_next;
    logic [53:0]      rem;
    logic [53:0]      dvs;
    logic [53:0]      rem_step;
    logic [55:0]      q;
    logic [55:0]      q_step;
    logic [CNT_W-1:0] cnt;
    logic             qbit;
    logic             special;
    logic             unused_payload;

    assign special = (|cls_a) | (|cls_b);
    assign q_step  = {q[54:0], qbit};

    // Payload bit 51 is overwritten by the quiet bit in the NaN result.
    assign unused_payload = nan_a[51] ^ nan_b[51];

    div_step u_step (
        .rem      (rem),
        .div      (dvs),
        .qbit     (qbit),
        .rem_next (rem_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = special ? DONE : DIV;
                end
            end
            DIV: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The last step writes the result straight from the step outputs, so DONE sees it at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            s   <= 1'b0;
            er  <= '0;
            fr  <= '0;
            flr <= '0;
            db  <= 1'b0;
            RM  <= '0;
            rem <= '0;
            dvs <= '0;
            q   <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s  <= sa ^ sb;
                        db <= db_in;
                        RM <= rm_in;
                        if (special) begin
                            er  <= '0;
                            fr  <= '0;
                            flr <= special_flags(cls_a, cls_b, nan_a[50:0], nan_b[50:0]);
                        end else begin
                            er  <= ea - eb;
                            rem <= {1'b0, fa};
                            dvs <= {1'b0, fb};
                            q   <= '0;
                            cnt <= db_in ? CNT_W'(DB_ITERS) : CNT_W'(SP_ITERS);
                        end
                    end
                end
                DIV: begin
                    rem <= rem_step;
                    q   <= q_step;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        flr <= '0;
                        if (db) begin
                            fr <= {q_step, |rem_step};
                        end else begin
                            fr <= {q_step[25:0], 30'b0, |rem_step};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_iter.sv
// Self-checking bench for fdiv_iter: directed cases, backpressure, mid-run reset and
// randomized operands against an exact integer-division reference model.
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        db_in;
    logic [1:0]  rm_in;
    logic        sa;
    logic        sb;
    logic [12:0] ea;
    logic [12:0] eb;
    logic [52:0] fa;
    logic [52:0] fb;
    logic [3:0]  cls_a;
    logic [3:0]  cls_b;
    logic [51:0] nan_a;
    logic [51:0] nan_b;
    logic        out_valid;
    logic        out_ready;
    logic        s;
    logic [12:0] er;
    logic [56:0] fr;
    logic [57:0] flr;
    logic        db;
    logic [1:0]  RM;

    int checks = 0;
    int errors = 0;

    logic        e_s;
    logic [12:0] e_er;
    logic [56:0] e_fr;
    logic [57:0] e_flr;
    int          e_lat;

    localparam logic [52:0] ONE   = 53'h10000000000000;
    localparam logic [52:0] ONE_5 = 53'h18000000000000;
    localparam logic [52:0] ONE_25 = 53'h14000000000000;

    fdiv_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .db_in     (db_in),
        .rm_in     (rm_in),
        .sa        (sa),
        .sb        (sb),
        .ea        (ea),
        .eb        (eb),
        .fa        (fa),
        .fb        (fb),
        .cls_a     (cls_a),
        .cls_b     (cls_b),
        .nan_a     (nan_a),
        .nan_b     (nan_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .er        (er),
        .fr        (fr),
        .flr       (flr),
        .db        (db),
        .RM        (RM)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic setOperands(input logic d, input logic [1:0] r, input logic as_, input logic bs_,
                               input logic [12:0] ae, input logic [12:0] be,
                               input logic [52:0] af, input logic [52:0] bf,
                               input logic [3:0] ca, input logic [3:0] cb,
                               input logic [51:0] na, input logic [51:0] nb);
        db_in = d;  rm_in = r;  sa = as_;  sb = bs_;
        ea = ae;    eb = be;    fa = af;   fb = bf;
        cls_a = ca; cls_b = cb; nan_a = na; nan_b = nb;
    endtask

    // Reference: the quotient is floor(fa * 2^(N-1) / fb) with a sticky for any remainder.
    task automatic refModel();
        logic        an, bn, az, bz, ai, bi;
        logic [127:0] num, quo, remd;
        logic [51:0] pay;
        an = cls_a[1] | cls_a[0];  bn = cls_b[1] | cls_b[0];
        az = cls_a[3];             bz = cls_b[3];
        ai = cls_a[2];             bi = cls_b[2];
        e_s = sa ^ sb;  e_er = '0;  e_fr = '0;  e_flr = '0;  e_lat = 1;
        if (an | bn) begin
            pay   = an ? nan_a : nan_b;
            e_flr = {1'b0, 1'b1, 1'b0, cls_a[0] | cls_b[0], 1'b0, 2'b01, pay[50:0]};
        end else if ((az & bz) | (ai & bi)) begin
            e_flr = {5'b01010, 2'b01, 51'b0};
        end else if (ai) begin
            e_flr = {5'b00100, 53'b0};
        end else if (bz) begin
            e_flr = {5'b00101, 53'b0};
        end else if (az | bi) begin
            e_flr = {5'b10000, 53'b0};
        end else begin
            e_er = ea - eb;
            if (db_in) begin
                num   = {75'b0, fa} << 55;
                quo   = num / {75'b0, fb};
                remd  = num % {75'b0, fb};
                e_fr  = {quo[55:0], remd != 0};
                e_lat = 57;
            end else begin
                num   = {75'b0, fa} << 25;
                quo   = num / {75'b0, fb};
                remd  = num % {75'b0, fb};
                e_fr  = {quo[25:0], 30'b0, remd != 0};
                e_lat = 27;
            end
        end
    endtask

    task automatic applyStimulus();
        int w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        checkOutput("in_ready_wait", in_ready, 1'b1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic runOp(input string tag, input bit release_out);
        int lat;
        refModel();
        applyStimulus();
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_lat"}, lat, e_lat);
        checkOutput({tag, "_s"}, s, e_s);
        checkOutput({tag, "_er"}, er, e_er);
        checkOutput({tag, "_fr"}, fr, e_fr);
        checkOutput({tag, "_flr"}, flr, e_flr);
        checkOutput({tag, "_db"}, db, db_in);
        checkOutput({tag, "_rm"}, RM, rm_in);
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checkOutput({tag, "_idle_ov"}, out_valid, 1'b0);
            checkOutput({tag, "_idle_ir"}, in_ready, 1'b1);
        end
    endtask

    function automatic logic [3:0] randClass();
        int r = $urandom_range(0, 15);
        case (r)
            0: return 4'b1000;
            1: return 4'b0100;
            2: return 4'b0010;
            3: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    initial begin
        rst = 1'b1;  in_valid = 1'b0;  out_ready = 1'b0;
        setOperands(1'b0, 2'b00, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ir", in_ready, 1'b1);
        checkOutput("rst_ov", out_valid, 1'b0);
        checkOutput("rst_out", {s, er, fr, flr, db, RM}, '0);
        rst = 1'b0;

        $display("[TB] directed: double 1.0/1.0");
        setOperands(1'b1, 2'b01, 1'b0, 1'b0, 13'd0, 13'd0, ONE, ONE, '0, '0, '0, '0);
        runOp("one", 1'b1);
        checkOutput("one_fr_const", fr, 57'h100000000000000);

        $display("[TB] directed: double 1.0/3.0");
        setOperands(1'b1, 2'b10, 1'b1, 1'b0, 13'd0, 13'd1, ONE, ONE_5, '0, '0, '0, '0);
        runOp("third", 1'b1);
        checkOutput("third_er_const", er, 13'h1FFF);
        checkOutput("third_top_const", fr[56:51], 6'b010101);

        $display("[TB] directed: single 1.5/1.0");
        setOperands(1'b0, 2'b11, 1'b0, 1'b1, 13'd3, 13'd1, ONE_5, ONE, '0, '0, '0, '0);
        runOp("sp", 1'b1);
        checkOutput("sp_fr_const", fr, {2'b11, 55'b0});

        $display("[TB] directed: 0/0 and 5/0");
        setOperands(1'b1, 2'b00, 1'b0, 1'b0, 13'd0, 13'd0, '0, '0, 4'b1000, 4'b1000, '0, '0);
        runOp("zz", 1'b1);
        checkOutput("zz_flags_const", flr[57:53], 5'b01010);
        setOperands(1'b1, 2'b00, 1'b1, 1'b0, 13'd2, 13'd0, ONE_25, '0, 4'b0000, 4'b1000, '0, '0);
        runOp("dbz", 1'b1);
        checkOutput("dbz_flags_const", flr[57:53], 5'b00101);

        $display("[TB] directed: backpressure in DONE");
        setOperands(1'b1, 2'b01, 1'b0, 1'b0, 13'd5, 13'd1, ONE, ONE_5, '0, '0, '0, '0);
        runOp("bp", 1'b0);
        setOperands(1'b0, 2'b10, 1'b1, 1'b1, 13'd7, 13'd2, ONE_5, ONE, '0, '0, '0, '0);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_ov", out_valid, 1'b1);
            checkOutput("bp_ir", in_ready, 1'b0);
            checkOutput("bp_hold", {s, er, fr, flr}, {e_s, e_er, e_fr, e_flr});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp_rel_ov", out_valid, 1'b0);
        checkOutput("bp_rel_ir", in_ready, 1'b1);

        $display("[TB] directed: reset during DIV");
        setOperands(1'b1, 2'b11, 1'b1, 1'b0, 13'd9, 13'd4, ONE_5, ONE, '0, '0, '0, '0);
        applyStimulus();
        repeat (19) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid_rst_ov", out_valid, 1'b0);
        checkOutput("mid_rst_ir", in_ready, 1'b1);
        checkOutput("mid_rst_out", {s, er, fr, flr, db, RM}, '0);
        setOperands(1'b1, 2'b00, 1'b0, 1'b0, 13'd0, 13'd0, ONE, ONE, '0, '0, '0, '0);
        runOp("post_rst", 1'b1);

        $display("[TB] randomized operands");
        for (int n = 0; n < 40; n++) begin
            setOperands(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                        13'($urandom), 13'($urandom),
                        {1'b1, 20'($urandom), 32'($urandom)},
                        {1'b1, 20'($urandom), 32'($urandom)},
                        randClass(), randClass(),
                        {20'($urandom), 32'($urandom)},
                        {20'($urandom), 32'($urandom)});
            runOp("rand", 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
